lsu_mem: RTL

- Load/store unit directly downstream of the execute stage. Consumes memory-class instructions (op codes 11–18: LB, LH, LW, LBU, LHU, SB, SH, SW) with an already-computed effective address and store data.
- Drives a single-outstanding data-bus request/grant/response handshake.
- Extracts and sign- or zero-extends load data, and produces a register write-back pulse.
- Raises hold2ctrl to stall the pipeline until the access completes.

---
 rtl/lsu_mem_if.sv | 22 ++
 rtl/lsu_mem.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_if.sv
// Data-bus bundle between the load/store unit (master) and the memory port (slave).
// Single outstanding request with request/grant, then a separate load response.
interface lsu_mem_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/lsu_mem.sv
// Load/store unit: one outstanding data-bus access, load extension, write-back pulse, stall.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned halfword/word accesses with bus_err.
module lsu_mem #(
   parameter int          TIMEOUT_CYCLES = 16,
   parameter logic [31:0] RST_DATA       = 32'h0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lsu_valid,
   input  logic [6:0]        oh,
   input  logic [31:0]       addr,
   input  logic [31:0]       st_data,
   input  logic [4:0]        rd_addr2lsu,
   lsu_mem_if.master         bus,
   output logic [4:0]        rd_addr,
   output logic [31:0]       rd_data,
   output logic              rd_wen2reg,
   output logic              hold2ctrl,
   output logic              bus_err
);

   localparam logic [6:0] OP_LB  = 7'd11;
   localparam logic [6:0] OP_LH  = 7'd12;
   localparam logic [6:0] OP_LW  = 7'd13;
   localparam logic [6:0] OP_LBU = 7'd14;
   localparam logic [6:0] OP_LHU = 7'd15;
   localparam logic [6:0] OP_SB  = 7'd16;
   localparam logic [6:0] OP_SH  = 7'd17;
   localparam logic [6:0] OP_SW  = 7'd18;
   localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

   state_t      state_q, state_d;
   logic [6:0]  op_q, op_d;
   logic [1:0]  off_q, off_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] maddr_q, maddr_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] wdata_q, wdata_d;
   logic [4:0]  rd_addr_q, rd_addr_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        wen_q, wen_d;
   logic        err_q, err_d;
   logic        accept, misal;

   function automatic logic is_store(input logic [6:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic [3:0] store_strb(input logic [6:0] op, input logic [1:0] off);
      case (op)
         OP_SB:   return 4'b0001 << off;
         OP_SH:   return 4'b0011 << {off[1], 1'b0};
         OP_SW:   return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] store_data(input logic [6:0] op, input logic [31:0] d);
      case (op)
         OP_SB:   return {4{d[7:0]}};
         OP_SH:   return {2{d[15:0]}};
         OP_SW:   return d;
         default: return RST_DATA;
      endcase
   endfunction

   function automatic logic [31:0] load_extract(input logic [6:0] op, input logic [1:0] off,
                                                input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{off, 3'b000} +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      case (op)
         OP_LB:   return {{24{b[7]}}, b};
         OP_LBU:  return {24'h0, b};
         OP_LH:   return {{16{h[15]}}, h};
         OP_LHU:  return {16'h0, h};
         default: return w;
      endcase
   endfunction

`ifdef LSU_MISALIGN_TRAP_EN
   function automatic logic misaligned(input logic [6:0] op, input logic [1:0] off);
      case (op)
         OP_LH, OP_LHU, OP_SH: return off[0];
         OP_LW, OP_SW:         return off != 2'b00;
         default:              return 1'b0;
      endcase
   endfunction
`endif

   assign accept = lsu_valid && (oh >= OP_LB) && (oh <= OP_SW);
`ifdef LSU_MISALIGN_TRAP_EN
   assign misal = misaligned(oh, addr[1:0]);
`else
   assign misal = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      off_d     = off_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      we_d      = we_q;
      maddr_d   = maddr_q;
      wstrb_d   = wstrb_q;
      wdata_d   = wdata_q;
      rd_addr_d = rd_addr_q;
      rd_data_d = rd_data_q;
      wen_d     = 1'b0;
      err_d     = 1'b0;
      hold2ctrl = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               hold2ctrl = 1'b1;
               op_d      = oh;
               off_d     = addr[1:0];
               rd_addr_d = rd_addr2lsu;
               cnt_d     = 8'd0;
               if (misal) begin
                  // Trap without touching the bus: no request, no write.
                  state_d = DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d = REQ;
                  req_d   = 1'b1;
                  we_d    = is_store(oh);
                  maddr_d = {addr[31:2], 2'b00};
                  wstrb_d = store_strb(oh, addr[1:0]);
                  wdata_d = store_data(oh, st_data);
               end
            end
         end
         REQ: begin
            hold2ctrl = 1'b1;
            if (bus.mem_gnt) begin
               req_d   = 1'b0;
               cnt_d   = 8'd0;
               state_d = is_store(op_q) ? DONE : RESP;
            end else if (cnt_q == TO_LIM) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               cnt_d   = 8'd0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP: begin
            hold2ctrl = 1'b1;
            if (bus.mem_rvalid) begin
               rd_data_d = load_extract(op_q, off_q, bus.mem_rdata);
               wen_d     = (rd_addr_q != 5'd0);
               state_d   = DONE;
            end else if (cnt_q == TO_LIM) begin
               err_d   = 1'b1;
               cnt_d   = 8'd0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         op_q      <= 7'd0;
         off_q     <= 2'd0;
         cnt_q     <= 8'd0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         maddr_q   <= 32'h0;
         wstrb_q   <= 4'h0;
         wdata_q   <= RST_DATA;
         rd_addr_q <= 5'd0;
         rd_data_q <= RST_DATA;
         wen_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         off_q     <= off_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         we_q      <= we_d;
         maddr_q   <= maddr_d;
         wstrb_q   <= wstrb_d;
         wdata_q   <= wdata_d;
         rd_addr_q <= rd_addr_d;
         rd_data_q <= rd_data_d;
         wen_q     <= wen_d;
         err_q     <= err_d;
      end
   end

   assign bus.mem_req   = req_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = maddr_q;
   assign bus.mem_wstrb = wstrb_q;
   assign bus.mem_wdata = wdata_q;
   assign rd_addr       = rd_addr_q;
   assign rd_data       = rd_data_q;
   assign rd_wen2reg    = wen_q;
   assign bus_err       = err_q;

endmodule
